countdown_timer: RTL

Loadable n-bit down-counter with start/pause/stop control, single-shot or periodic auto-reload, and a registered terminal-count pulse. It is the counting-down complement of the team's loadable up-counter. Control logic uses it to generate timeouts and fixed-period ticks: software or an FSM loads a period, starts the timer, and reacts to `tc`.

---
 rtl/countdown_timer.sv | 108 ++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause/stop control, single-shot or periodic
// auto-reload, and a registered one-cycle terminal-count pulse.
module countdown_timer #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [n-1:0] load_data,
    input  logic         start,
    input  logic         pause,
    input  logic         stop,
    input  logic         periodic,
    output logic [n-1:0] count,
    output logic         busy,
    output logic         tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [n-1:0] one = n'(1);

    state_t       state;
    state_t       state_nxt;
    logic [n-1:0] reload;
    logic [n-1:0] count_nxt;
    logic         tc_nxt;
    logic         stepping;
    logic         at_one;
    logic         reload_ok;

    // A RUN cycle only advances the count when nothing of higher priority claims the edge.
    assign stepping  = (state == RUN) && !load && !stop && !pause;
    assign at_one    = (count == one);
    assign reload_ok = periodic && (reload != '0);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (count != '0)) state_nxt = RUN;
                end
                RUN: begin
                    if (stop)                     state_nxt = IDLE;
                    else if (pause)               state_nxt = HOLD;
                    else if (count == '0)         state_nxt = IDLE;
                    else if (at_one && !reload_ok) state_nxt = IDLE;
                end
                HOLD: begin
                    if (stop)        state_nxt = IDLE;
                    else if (!pause) state_nxt = RUN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Count / terminal-count datapath
    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        if (load) begin
            count_nxt = load_data;
        end else if (stepping) begin
            if (count > one) begin
                count_nxt = count - one;
            end else if (at_one) begin
                tc_nxt    = 1'b1;
                count_nxt = reload_ok ? reload : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            reload <= '0;
            count  <= '0;
            tc     <= 1'b0;
        end else begin
            if (load) reload <= load_data;
            count <= count_nxt;
            tc    <= tc_nxt;
        end
    end

    // Output decode
    always_comb begin
        busy = (state == RUN) || (state == HOLD);
    end

endmodule
